// File: rtl/frame_sample_loader.sv
// Fetches N_SAMPLES consecutive RAM words, extends each to SAMPLE_W bits and presents
// them as one parallel frame, then holds the frame and handshakes with the FFT core.
module frame_sample_loader #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 16,
    parameter int SAMPLE_W    = 24,
    parameter int N_SAMPLES   = 16,
    parameter int RD_LATENCY  = 2,
    parameter int HOLD_CYCLES = 33554431,
    parameter int BASE_ADDR   = 0,
    parameter int END_ADDR    = 32767,
    parameter bit SIGNED      = 1'b1
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            fft_done,
    input  logic                            free_run,
    input  logic [DATA_W-1:0]               ram_q,
    output logic [ADDR_W-1:0]               ram_addr,
    output logic                            ram_rden,
    output logic [N_SAMPLES*SAMPLE_W-1:0]   samples,
    output logic                            ready,
    output logic                            frame_valid,
    output logic                            busy
);

    localparam int IDX_W  = (N_SAMPLES > 2) ? $clog2(N_SAMPLES) : 1;
    localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

    generate
        if (SAMPLE_W < DATA_W || N_SAMPLES < 2 || END_ADDR < BASE_ADDR || RD_LATENCY < 1) begin : g_bad_params
            $error("frame_sample_loader: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_ADVANCE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               ram_addr_q, ram_addr_d;
    logic                            ram_rden_q, ram_rden_d;
    logic [N_SAMPLES*SAMPLE_W-1:0]   samples_q, samples_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [LAT_W-1:0]                lat_cnt_q, lat_cnt_d;
    logic [HOLD_W-1:0]               hold_cnt_q, hold_cnt_d;
    logic                            frame_valid_q, frame_valid_d;
    logic                            busy_q, busy_d;
    logic [SAMPLE_W-1:0]             ext_sample;

    always_comb begin
        if (SIGNED) ext_sample = SAMPLE_W'($signed(ram_q));
        else        ext_sample = SAMPLE_W'(ram_q);
    end

    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        samples_d  = samples_q;
        idx_d      = idx_q;
        lat_cnt_d  = lat_cnt_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (fft_done || free_run) begin
                    lat_cnt_d = '0;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                if (lat_cnt_q == LAT_W'(RD_LATENCY - 1)) begin
                    lat_cnt_d = '0;
                    state_d   = S_CAPTURE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                for (int k = 0; k < N_SAMPLES; k++) begin
                    if (idx_q == IDX_W'(k)) samples_d[k*SAMPLE_W +: SAMPLE_W] = ext_sample;
                end
                state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                // The address survives across frames so successive frames walk the window.
                if (ram_addr_q == ADDR_W'(END_ADDR)) ram_addr_d = ADDR_W'(BASE_ADDR);
                else                                 ram_addr_d = ram_addr_q + 1'b1;
                if (idx_q == IDX_W'(N_SAMPLES - 1)) begin
                    idx_d      = '0;
                    hold_cnt_d = '0;
                    state_d    = S_HOLD;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_W'(HOLD_CYCLES)) begin
                    hold_cnt_d = '0;
                    state_d    = S_DONE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ram_rden_d    = (state_d == S_READ) || (state_d == S_CAPTURE);
        busy_d        = (state_d == S_READ) || (state_d == S_CAPTURE) || (state_d == S_ADVANCE);
        frame_valid_d = (state_q == S_ADVANCE) && (state_d == S_HOLD);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            ram_addr_q    <= ADDR_W'(BASE_ADDR);
            ram_rden_q    <= 1'b0;
            samples_q     <= '0;
            idx_q         <= '0;
            lat_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ram_addr_q    <= ram_addr_d;
            ram_rden_q    <= ram_rden_d;
            samples_q     <= samples_d;
            idx_q         <= idx_d;
            lat_cnt_q     <= lat_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_rden    = ram_rden_q;
    assign samples     = samples_q;
    assign frame_valid = frame_valid_q;
    assign busy        = busy_q;
    assign ready       = (state_q == S_IDLE) || (state_q == S_DONE);

endmodule

// File: tb/tb_frame_sample_loader.sv
// Bench for frame_sample_loader: random RAM contents, reference model of the
// sample window walk and frame timing derived from cycle arithmetic.
module tb_frame_sample_loader;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 16;
    localparam int SAMPLE_W    = 24;
    localparam int N_SAMPLES   = 6;
    localparam int RD_LATENCY  = 2;
    localparam int HOLD_CYCLES = 3;
    localparam int BASE_ADDR   = 10;
    localparam int END_ADDR    = 25;
    localparam bit SIGNED      = 1'b1;

    localparam int PER_SAMPLE  = RD_LATENCY + 2;
    localparam int FV_CYCLE    = N_SAMPLES * PER_SAMPLE + 1;
    localparam int DONE_CYCLE  = FV_CYCLE + HOLD_CYCLES + 1;

    logic                          Clk = 1'b0;
    logic                          Reset;
    logic                          fft_done;
    logic                          free_run;
    logic [DATA_W-1:0]             ram_q;
    logic [ADDR_W-1:0]             ram_addr;
    logic                          ram_rden;
    logic [N_SAMPLES*SAMPLE_W-1:0] samples;
    logic                          ready;
    logic                          frame_valid;
    logic                          busy;

    frame_sample_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W), .N_SAMPLES(N_SAMPLES),
        .RD_LATENCY(RD_LATENCY), .HOLD_CYCLES(HOLD_CYCLES), .BASE_ADDR(BASE_ADDR),
        .END_ADDR(END_ADDR), .SIGNED(SIGNED)
    ) dut (
        .Clk(Clk), .Reset(Reset), .fft_done(fft_done), .free_run(free_run), .ram_q(ram_q),
        .ram_addr(ram_addr), .ram_rden(ram_rden), .samples(samples), .ready(ready),
        .frame_valid(frame_valid), .busy(busy)
    );

    always #10 Clk = ~Clk;

    // RAM with a RD_LATENCY-deep read pipeline.
    logic [DATA_W-1:0] mem  [1 << ADDR_W];
    logic [DATA_W-1:0] pipe [RD_LATENCY];
    always @(posedge Clk) begin
        pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_q = pipe[RD_LATENCY-1];

    int                  errors = 0;
    int                  checks = 0;
    int                  exp_addr;
    logic [SAMPLE_W-1:0] exp_samples [N_SAMPLES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SAMPLE_W-1:0] ext(input logic [DATA_W-1:0] d);
        int v;
        v = int'(d);
        if (SIGNED && v >= (1 << (DATA_W - 1))) v = v - (1 << DATA_W);
        return SAMPLE_W'(v);
    endfunction

    task automatic check_samples(input string tag);
        for (int k = 0; k < N_SAMPLES; k++)
            check($sformatf("%s_slot%0d", tag, k), 32'(samples[k*SAMPLE_W +: SAMPLE_W]), 32'(exp_samples[k]));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rden"}, 32'(ram_rden), 32'd0);
        check({tag, "_fv"}, 32'(frame_valid), 32'd0);
    endtask

    task automatic model_reset();
        exp_addr = BASE_ADDR;
        for (int k = 0; k < N_SAMPLES; k++) exp_samples[k] = '0;
    endtask

    // Called at the negedge of cycle 0 with the trigger already applied; returns at DONE.
    task automatic run_frame(input string tag, input bit jitter);
        bit exp_rden, exp_busy, exp_fv, exp_ready;
        for (int k = 0; k < N_SAMPLES; k++) begin
            exp_samples[k] = ext(mem[exp_addr]);
            exp_addr = (exp_addr == END_ADDR) ? BASE_ADDR : exp_addr + 1;
        end
        for (int c = 1; c <= DONE_CYCLE; c++) begin
            @(negedge Clk);
            exp_rden  = (c < FV_CYCLE) && (((c - 1) % PER_SAMPLE) <= RD_LATENCY);
            exp_busy  = (c < FV_CYCLE);
            exp_fv    = (c == FV_CYCLE);
            exp_ready = (c == DONE_CYCLE);
            check($sformatf("%s_c%0d_rden", tag, c), 32'(ram_rden), 32'(exp_rden));
            check($sformatf("%s_c%0d_busy", tag, c), 32'(busy), 32'(exp_busy));
            check($sformatf("%s_c%0d_fv", tag, c), 32'(frame_valid), 32'(exp_fv));
            check($sformatf("%s_c%0d_ready", tag, c), 32'(ready), 32'(exp_ready));
            fft_done = (jitter && c != DONE_CYCLE) ? 1'($urandom) : 1'b0;
        end
        check_samples(tag);
        check({tag, "_addr"}, 32'(ram_addr), 32'(exp_addr));
    endtask

    initial begin
        Reset    = 1'b1;
        fft_done = 1'b0;
        free_run = 1'b0;
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 16'($urandom);
        mem[BASE_ADDR]     = 16'h8001;
        mem[BASE_ADDR + 1] = 16'h7FFF;
        model_reset();

        repeat (3) @(negedge Clk);
        check_idle("reset");
        check("reset_addr", 32'(ram_addr), 32'(BASE_ADDR));
        check_samples("reset");
        Reset = 1'b0;
        @(negedge Clk);
        check_idle("idle0");

        // Frame 1: single fft_done pulse, sign extension of 16'h8001 and 16'h7FFF.
        fft_done = 1'b1;
        run_frame("f1", 1'b0);
        check("f1_ext8001", 32'(samples[0 +: SAMPLE_W]), 32'h00FF8001);
        check("f1_ext7fff", 32'(samples[SAMPLE_W +: SAMPLE_W]), 32'h00007FFF);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check_idle($sformatf("f1_idle%0d", i));
        end

        // Frames 2 and 3: fft_done toggles mid-frame and must be ignored; frame 3 wraps.
        for (int f = 2; f <= 3; f++) begin
            fft_done = 1'b1;
            run_frame($sformatf("f%0d", f), 1'b1);
            @(negedge Clk);
            check_idle($sformatf("f%0d_idle", f));
        end

        // Free-run: back-to-back frames with exactly one DONE and one IDLE cycle.
        free_run = 1'b1;
        run_frame("fr0", 1'b1);
        for (int f = 1; f <= 2; f++) begin
            @(negedge Clk);
            check_idle($sformatf("fr%0d_gap", f));
            run_frame($sformatf("fr%0d", f), 1'b1);
        end
        free_run = 1'b0;
        @(negedge Clk);
        check_idle("fr_end");

        // Reset in the CAPTURE cycle of sample 5.
        fft_done = 1'b1;
        for (int c = 1; c <= 5 * PER_SAMPLE + RD_LATENCY + 1; c++) begin
            @(negedge Clk);
            fft_done = 1'b0;
        end
        check("abort_rden_in_capture", 32'(ram_rden), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        model_reset();
        check_idle("abort");
        check("abort_addr", 32'(ram_addr), 32'(BASE_ADDR));
        check_samples("abort");
        Reset = 1'b0;
        for (int i = 0; i < 2 * FV_CYCLE; i++) begin
            @(negedge Clk);
            check($sformatf("abort_nofv%0d", i), 32'(frame_valid), 32'd0);
        end

        fft_done = 1'b1;
        run_frame("post", 1'b0);
        check("post_ext8001", 32'(samples[0 +: SAMPLE_W]), 32'h00FF8001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
